// File: rtl/pic24_icsp_responder.sv
// PIC24 ICSP target-side responder.
// Detects the ICSP entry key, decodes SIX / REGOUT commands from the PGC/PGD link,
// and shifts a 16-bit VISI word back on REGOUT.
// Optional feature macro: ICSP_KEY_CHECK_EN (compare the received entry key against KEY).
module pic24_icsp_responder #(
  parameter logic [31:0] KEY = 32'h4D434851
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        PGCx,
  input  logic        PGDx_in,
  output logic        PGDx_out,
  output logic        PGDx_dir,
  input  logic        MCLRn,
  input  logic [15:0] visi_in,
  output logic        entered,
  output logic        cmd_valid,
  output logic [3:0]  cmd_op,
  output logic [23:0] cmd_data,
  output logic        cmd_err
);

  typedef enum logic [2:0] {
    StIdle,
    StKey,
    StCmd,
    StSix,
    StRoIdle,
    StRoData,
    StLost
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  pgc_sync_q, pgc_sync_d;
  logic [1:0]  pgd_sync_q, pgd_sync_d;
  logic [1:0]  mclr_sync_q, mclr_sync_d;
  logic        pgc_prev_q, pgc_prev_d;
  logic        mclr_prev_q, mclr_prev_d;
  logic [31:0] key_q, key_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [23:0] data_q, data_d;
  logic [15:0] visi_q, visi_d;
  logic        out_q, out_d;
  logic        dir_q, dir_d;
  logic        entered_q, entered_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [3:0]  op_q, op_d;
  logic [23:0] cmd_data_q, cmd_data_d;

  logic        pgc_rise, pgc_fall, mclr_low, mclr_rise, pgd;
  logic        key_match;
  logic [3:0]  op_new;
  logic [23:0] data_shift;

`ifdef ICSP_KEY_CHECK_EN
  assign key_match = (key_q == KEY);
`else
  logic unused_key;
  assign unused_key = ^KEY;
  assign key_match  = 1'b1;
`endif

  // Synchronizer shift stages and edge-detect history.
  always_comb begin
    pgc_sync_d  = {pgc_sync_q[0], PGCx};
    pgd_sync_d  = {pgd_sync_q[0], PGDx_in};
    mclr_sync_d = {mclr_sync_q[0], MCLRn};
    pgc_prev_d  = pgc_sync_q[1];
    mclr_prev_d = mclr_sync_q[1];
  end

  assign pgc_rise   = pgc_sync_q[1] & ~pgc_prev_q;
  assign pgc_fall   = ~pgc_sync_q[1] & pgc_prev_q;
  assign mclr_low   = ~mclr_sync_q[1];
  assign mclr_rise  = mclr_sync_q[1] & ~mclr_prev_q;
  assign pgd        = pgd_sync_q[1];
  // Serial fields arrive LSb first, so new bits enter at the top.
  assign data_shift = {pgd, data_q[23:1]};
  assign op_new     = data_shift[23:20];

  // Next-state and output logic for the ICSP protocol FSM.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    visi_d     = visi_q;
    out_d      = out_q;
    dir_d      = dir_q;
    entered_d  = entered_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    op_d       = op_q;
    cmd_data_d = cmd_data_q;

    // MCLRn abort wins over any coincident PGC edge.
    if (state_q != StIdle && state_q != StKey && mclr_low) begin
      state_d   = StKey;
      key_d     = '0;
      cnt_d     = '0;
      entered_d = 1'b0;
      dir_d     = 1'b0;
      out_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mclr_low) begin
            state_d = StKey;
            key_d   = '0;
            cnt_d   = '0;
          end
        end
        StKey: begin
          if (pgc_rise) begin
            key_d = {key_q[30:0], pgd};
            if (cnt_q < 6'd32) cnt_d = cnt_q + 6'd1;
          end
          if (mclr_rise) begin
            if (cnt_q >= 6'd32 && key_match) begin
              state_d   = StCmd;
              entered_d = 1'b1;
              cnt_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StCmd: begin
          if (pgc_rise) begin
            data_d = data_shift;
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'd3) begin
              cnt_d = '0;
              if (op_new == 4'b0000) begin
                state_d = StSix;
              end else if (op_new == 4'b0001) begin
                state_d    = StRoIdle;
                valid_d    = 1'b1;
                op_d       = 4'd1;
                cmd_data_d = '0;
              end else begin
                state_d = StLost;
                err_d   = 1'b1;
              end
            end
          end
        end
        StSix: begin
          if (pgc_rise) begin
            data_d = data_shift;
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'd23) begin
              cnt_d      = '0;
              state_d    = StCmd;
              valid_d    = 1'b1;
              op_d       = 4'd0;
              cmd_data_d = data_shift;
            end
          end
        end
        StRoIdle: begin
          if (pgc_rise) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd7) begin
              cnt_d   = '0;
              visi_d  = visi_in;
              state_d = StRoData;
            end
          end
        end
        StRoData: begin
          // Present the next bit on each fall; the programmer samples on the rise.
          if (pgc_fall) begin
            dir_d  = 1'b1;
            out_d  = visi_q[0];
            visi_d = {1'b0, visi_q[15:1]};
          end
          if (pgc_rise) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd15) begin
              cnt_d   = '0;
              dir_d   = 1'b0;
              out_d   = 1'b0;
              state_d = StCmd;
            end
          end
        end
        StLost: begin
          state_d = StLost;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers; MCLRn sync resets released-high so reset does not look like entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      pgc_sync_q  <= '0;
      pgd_sync_q  <= '0;
      mclr_sync_q <= 2'b11;
      pgc_prev_q  <= 1'b0;
      mclr_prev_q <= 1'b1;
      key_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      visi_q      <= '0;
      out_q       <= 1'b0;
      dir_q       <= 1'b0;
      entered_q   <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= '0;
      cmd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pgc_sync_q  <= pgc_sync_d;
      pgd_sync_q  <= pgd_sync_d;
      mclr_sync_q <= mclr_sync_d;
      pgc_prev_q  <= pgc_prev_d;
      mclr_prev_q <= mclr_prev_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      visi_q      <= visi_d;
      out_q       <= out_d;
      dir_q       <= dir_d;
      entered_q   <= entered_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      op_q        <= op_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign PGDx_out  = out_q;
  assign PGDx_dir  = dir_q;
  assign entered   = entered_q;
  assign cmd_valid = valid_q;
  assign cmd_err   = err_q;
  assign cmd_op    = op_q;
  assign cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_pic24_icsp_responder.sv
// Scoreboard bench for pic24_icsp_responder: the driver pushes expected command
// reports, an independent monitor pops them whenever cmd_valid / cmd_err fire.
module tb_pic24_icsp_responder;

  localparam int          Half   = 6;
  localparam logic [31:0] KeyVal = 32'h4D434851;

  typedef struct packed {
    logic        err;
    logic [3:0]  op;
    logic [23:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn, pgc, pgd_in, pgd_out, pgd_dir, mclrn;
  logic [15:0] visi;
  logic        entered, cmd_valid, cmd_err;
  logic [3:0]  cmd_op;
  logic [23:0] cmd_data;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  // Reference model state: does the target currently accept commands, and last report.
  bit          in_cmd = 1'b0;
  logic [3:0]  last_op = '0;
  logic [23:0] last_data = '0;

  always #5 clk = ~clk;

  pic24_icsp_responder dut (
    .clk      (clk),
    .rstn     (rstn),
    .PGCx     (pgc),
    .PGDx_in  (pgd_in),
    .PGDx_out (pgd_out),
    .PGDx_dir (pgd_dir),
    .MCLRn    (mclrn),
    .visi_in  (visi),
    .entered  (entered),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_err  (cmd_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic bit key_ok(input logic [31:0] k);
`ifdef ICSP_KEY_CHECK_EN
    return k == KeyVal;
`else
    return (k == k);
`endif
  endfunction

  // Monitor: every report from the DUT must match the head of the queue.
  always @(negedge clk) begin
    if (rstn && (cmd_valid || cmd_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_report", {cmd_err, cmd_op, cmd_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("report_kind", {cmd_valid, cmd_err}, {~e.err, e.err});
        if (!e.err) check("report_payload", {cmd_op, cmd_data}, {e.op, e.data});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pgc_cycle(input logic d, output logic so, output logic sd);
    pgd_in = d;
    wait_clk(Half);
    so = pgd_out;
    sd = pgd_dir;
    pgc = 1'b1;
    wait_clk(Half);
    pgc = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit msb_first);
    logic so, sd;
    for (int i = 0; i < n; i++) pgc_cycle(msb_first ? v[n-1-i] : v[i], so, sd);
  endtask

  task automatic send_random(input int n);
    logic so, sd;
    for (int i = 0; i < n; i++) pgc_cycle(1'($urandom), so, sd);
  endtask

  task automatic enter(input logic [31:0] k, input int extra);
    pgc   = 1'b0;
    mclrn = 1'b0;
    wait_clk(Half);
    send_random(extra);
    send_bits(k, 32, 1'b1);
    wait_clk(Half);
    mclrn = 1'b1;
    wait_clk(3);
    in_cmd = key_ok(k);
    check("entered_after_key", {31'd0, entered}, {31'd0, in_cmd});
    check("dir_after_key", {31'd0, pgd_dir}, 32'd0);
  endtask

  task automatic six(input logic [23:0] d);
    if (in_cmd) begin
      exp_q.push_back('{err: 1'b0, op: 4'd0, data: d});
      last_op   = 4'd0;
      last_data = d;
    end
    send_bits(32'd0, 4, 1'b0);
    send_bits({8'd0, d}, 24, 1'b0);
  endtask

  // Opcode plus 8 idle clocks plus n VISI clocks; returns the bits sampled on rises.
  task automatic regout_n(input logic [15:0] v, input int n, output logic [15:0] word,
                          output logic alldir);
    logic so, sd;
    visi   = v;
    word   = '0;
    alldir = 1'b1;
    if (in_cmd) begin
      exp_q.push_back('{err: 1'b0, op: 4'd1, data: 24'd0});
      last_op   = 4'd1;
      last_data = 24'd0;
    end
    send_bits(32'd1, 4, 1'b0);
    send_random(8);
    for (int i = 0; i < n; i++) begin
      pgc_cycle(1'($urandom), so, sd);
      word[i] = so;
      alldir  = alldir & sd;
    end
  endtask

  task automatic regout(input logic [15:0] v);
    logic [15:0] word;
    logic        alldir;
    regout_n(v, 16, word, alldir);
    if (in_cmd) begin
      check("visi_word", {16'd0, word}, {16'd0, v});
      check("visi_dir_high", {31'd0, alldir}, 32'd1);
      check("visi_dir_released", {31'd0, pgd_dir}, 32'd0);
    end
  endtask

  task automatic bad_op(input logic [3:0] op);
    if (in_cmd) exp_q.push_back('{err: 1'b1, op: op, data: 24'd0});
    send_bits({28'd0, op}, 4, 1'b0);
    in_cmd = 1'b0;
  endtask

  initial begin
    logic [15:0] word;
    logic        alldir;

    rstn   = 1'b0;
    pgc    = 1'b0;
    pgd_in = 1'b0;
    mclrn  = 1'b1;
    visi   = '0;
    wait_clk(4);
    check("reset_outputs", {entered, cmd_valid, cmd_err, pgd_dir, pgd_out, cmd_op, cmd_data},
          32'd0);
    rstn = 1'b1;
    wait_clk(4);
    check("idle_outputs", {entered, cmd_valid, cmd_err, pgd_dir, pgd_out, cmd_op, cmd_data},
          32'd0);

    // MCLRn toggle without PGC clocks must not enter.
    mclrn = 1'b0;
    wait_clk(Half);
    mclrn = 1'b1;
    wait_clk(Half);
    check("toggle_no_entry", {31'd0, entered}, 32'd0);

    enter(32'h4D434850, 0);
    enter(KeyVal, 0);
    six(24'hABCDEF);
    six(24'h000000);
    check("hold_after_six", {4'd0, cmd_op, cmd_data}, {4'd0, last_op, last_data});
    regout(16'hA5C3);

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0, 1: six(24'($urandom));
        2: regout(16'($urandom));
        default: enter(KeyVal, $urandom_range(1, 8));
      endcase
    end
    check("hold_after_random", {4'd0, cmd_op, cmd_data}, {4'd0, last_op, last_data});

    // Unknown opcode: error pulse then nothing until a fresh entry.
    bad_op(4'b0101);
    send_random(40);
    enter(KeyVal, 0);
    six(24'($urandom));

    // Abort in the middle of a VISI readback.
    regout_n(16'h5A3C, 7, word, alldir);
    check("partial_bits", {25'd0, word[6:0]}, {25'd0, 7'h3C});
    wait_clk(4);
    check("dir_before_abort", {31'd0, pgd_dir}, 32'd1);
    mclrn = 1'b0;
    wait_clk(3);
    in_cmd = 1'b0;
    check("abort_outputs", {30'd0, pgd_dir, entered}, 32'd0);
    wait_clk(Half);
    mclrn = 1'b1;
    wait_clk(Half);

    enter(KeyVal, 0);
    check("hold_after_abort", {4'd0, cmd_op, cmd_data}, {4'd0, last_op, last_data});
    regout_n(16'hFFFF, 3, word, alldir);
    wait_clk(4);
    check("dir_out_before_reset", {30'd0, pgd_dir, pgd_out}, 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_outputs",
          {entered, cmd_valid, cmd_err, pgd_dir, pgd_out, cmd_op, cmd_data}, 32'd0);
    wait_clk(4);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
